// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone classic interconnect.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Mask/base address decoder: lowest matching slave index wins.
module wb_addr_decoder
    import wb_pkg::*;
#(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           IDX_W      = idx_w(NUM_SLAVES),
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] adr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & SLAVE_MASK[i*ADDR_W +: ADDR_W])
                    == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_intercon.sv
// Single-master, N-slave Wishbone classic interconnect with
// registered responses, timeout watchdog and error logging.
module wb_intercon
    import wb_pkg::*;
#(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h300, 32'h200, 32'h100, 32'h000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {4{32'hFFFFFF00}},
    parameter int                           TIMEOUT    = 16,
    parameter logic [DATA_W-1:0]            ERR_DATA   =
        DATA_W'(ERR_DATA_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            m_adr_i,
    input  logic [DATA_W-1:0]            m_dat_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    input  logic                         m_we_i,
    input  logic                         m_stb_i,
    input  logic                         m_cyc_i,
    output logic [DATA_W-1:0]            m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [ADDR_W-1:0]            s_adr_o,
    output logic [DATA_W-1:0]            s_dat_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic                         s_we_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES-1:0]        s_err_i,
    output logic [ADDR_W-1:0]            err_adr_o,
    output logic [7:0]                   err_cnt_o
);

    localparam int IDX_W = idx_w(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W/8-1:0] sel_q;
    logic                we_q;
    logic [IDX_W-1:0]    idx_q;
    logic                ack_q, ack_n;
    logic                err_q, err_n;
    logic [DATA_W-1:0]   rdat_q, rdat_n;
    logic [ADDR_W-1:0]   err_adr_q, err_adr_n;
    logic [7:0]          err_cnt_q;
    logic                latch, log_err;
    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic [DATA_W-1:0]   sel_rdat;
    logic [NUM_SLAVES-1:0] sel_onehot;

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .adr (m_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign sel_rdat = s_dat_i[int'(idx_q)*DATA_W +: DATA_W];

    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        latch     = 1'b0;
        ack_n     = 1'b0;
        err_n     = 1'b0;
        rdat_n    = rdat_q;
        log_err   = 1'b0;
        err_adr_n = err_adr_q;
        unique case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    latch = 1'b1;
                    if (dec_hit) begin
                        state_n = ACTIVE;
                    end else begin
                        state_n   = RESP;
                        err_n     = 1'b1;
                        rdat_n    = ERR_DATA;
                        log_err   = 1'b1;
                        err_adr_n = m_adr_i;
                    end
                end
            end
            ACTIVE: begin
                // Abort beats any response arriving in the same cycle.
                if (!m_cyc_i) begin
                    state_n = IDLE;
                end else if (s_err_i[idx_q] || cnt == CNT_LAST) begin
                    state_n   = RESP;
                    err_n     = 1'b1;
                    rdat_n    = ERR_DATA;
                    log_err   = 1'b1;
                    err_adr_n = adr_q;
                end else if (s_ack_i[idx_q]) begin
                    state_n = RESP;
                    ack_n   = 1'b1;
                    rdat_n  = we_q ? '0 : sel_rdat;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            err_adr_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ack_q     <= ack_n;
            err_q     <= err_n;
            rdat_q    <= rdat_n;
            err_adr_q <= err_adr_n;
            if (latch) begin
                adr_q <= m_adr_i;
                dat_q <= m_dat_i;
                sel_q <= m_sel_i;
                we_q  <= m_we_i;
                idx_q <= dec_idx;
            end
            if (log_err && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign sel_onehot = (state == ACTIVE)
                      ? (NUM_SLAVES'(1) << idx_q) : '0;

    assign s_stb_o   = sel_onehot;
    assign s_cyc_o   = sel_onehot;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = dat_q;
    assign s_sel_o   = sel_q;
    assign s_we_o    = we_q;
    assign m_ack_o   = ack_q;
    assign m_err_o   = err_q;
    assign m_dat_o   = rdat_q;
    assign err_adr_o = err_adr_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: a per-cycle timeline model of the
// expected bus behaviour is built per transfer and compared every cycle.
module tb_wb_intercon;

    localparam int          N    = 4;
    localparam int          MAXC = 2048;
    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;
    localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2, M_ABORT = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  m_adr_i = '0;
    logic [31:0]  m_dat_i = '0;
    logic [3:0]   m_sel_i = '0;
    logic         m_we_i = 1'b0;
    logic         m_stb_i = 1'b0;
    logic         m_cyc_i = 1'b0;
    logic [31:0]  m_dat_o;
    logic         m_ack_o, m_err_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [3:0]   s_stb_o, s_cyc_o;
    logic [127:0] s_dat_i = '0;
    logic [3:0]   s_ack_i = '0;
    logic [3:0]   s_err_i = '0;
    logic [31:0]  err_adr_o;
    logic [7:0]   err_cnt_o;

    wb_intercon dut (
        .clk       (clk),
        .reset     (reset),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_we_i    (m_we_i),
        .m_stb_i   (m_stb_i),
        .m_cyc_i   (m_cyc_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .err_adr_o (err_adr_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    // Expected timeline, indexed by cycle number.
    logic [3:0]  e_stb  [MAXC];
    logic        e_ack  [MAXC];
    logic        e_err  [MAXC];
    logic [31:0] e_dat  [MAXC];
    logic [31:0] e_adr  [MAXC];
    logic [31:0] e_wdat [MAXC];
    logic        e_we   [MAXC];
    logic [3:0]  e_sel  [MAXC];
    logic [7:0]  e_cnt  [MAXC];
    logic [31:0] e_eadr [MAXC];

    int cyc  = 0;
    int vecs = 0;
    int bad  = 0;
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h",
                     nm, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (cyc < MAXC) begin
                chk("s_stb", 32'(s_stb_o), 32'(e_stb[cyc]));
                chk("s_cyc", 32'(s_cyc_o), 32'(e_stb[cyc]));
                chk("m_ack", 32'(m_ack_o), 32'(e_ack[cyc]));
                chk("m_err", 32'(m_err_o), 32'(e_err[cyc]));
                chk("err_cnt", 32'(err_cnt_o), 32'(e_cnt[cyc]));
                chk("err_adr", err_adr_o, e_eadr[cyc]);
                chk("ack_err_excl", 32'(m_ack_o & m_err_o), 32'd0);
                if (e_ack[cyc] || e_err[cyc])
                    chk("m_dat", m_dat_o, e_dat[cyc]);
                if (e_stb[cyc] != 4'd0) begin
                    chk("s_adr", s_adr_o, e_adr[cyc]);
                    chk("s_dat", s_dat_o, e_wdat[cyc]);
                    chk("s_we", 32'(s_we_o), 32'(e_we[cyc]));
                    chk("s_sel", 32'(s_sel_o), 32'(e_sel[cyc]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            m_cyc_i = 1'b0;
            m_stb_i = 1'b0;
            m_we_i  = 1'b0;
            s_ack_i = '0;
            s_err_i = '0;
        end
    endtask

    // Address map: slave i owns 0x100*i .. 0x100*i+0xFF.
    function automatic void decode(input logic [31:0] a,
                                   output logic h, output int ix);
        h  = 1'b0;
        ix = 0;
        for (int i = 0; i < N; i++) begin
            if (!h && (a & 32'hFFFFFF00) == 32'(i * 256)) begin
                h  = 1'b1;
                ix = i;
            end
        end
    endfunction

    function automatic void log_err(input int c, input logic [31:0] a);
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        for (int k = c; k < MAXC; k++) begin
            e_cnt[k]  = 8'(m_cnt);
            e_eadr[k] = a;
        end
    endfunction

    function automatic void model_reset(input int c);
        m_cnt = 0;
        for (int k = c; k < MAXC; k++) begin
            e_cnt[k]  = '0;
            e_eadr[k] = '0;
        end
    endfunction

    // One master transfer. Request is presented in cycle 'base'; returns
    // in cycle 'endc' (response pulse, or the cycle cyc was dropped).
    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [3:0] sel,
                        input int mode, input int w,
                        input logic [31:0] rd, input logic [3:0] stray,
                        output int base, output int endc);
        logic h;
        int   ix, last;
        step();
        base    = cyc;
        m_adr_i = a;
        m_dat_i = d;
        m_we_i  = we;
        m_sel_i = sel;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_ack_i = stray;
        s_err_i = '0;
        decode(a, h, ix);
        if (!h) begin
            endc        = base + 1;
            e_err[endc] = 1'b1;
            e_dat[endc] = ERRD;
            log_err(endc, a);
        end else begin
            case (mode)
                M_ACK: begin
                    last        = base + 1 + w;
                    endc        = last + 1;
                    e_ack[endc] = 1'b1;
                    e_dat[endc] = we ? 32'd0 : rd;
                end
                M_ERR: begin
                    last        = base + 1 + w;
                    endc        = last + 1;
                    e_err[endc] = 1'b1;
                    e_dat[endc] = ERRD;
                    log_err(endc, a);
                end
                M_NONE: begin
                    last        = base + TO;
                    endc        = last + 1;
                    e_err[endc] = 1'b1;
                    e_dat[endc] = ERRD;
                    log_err(endc, a);
                end
                default: begin
                    last = base + w;
                    endc = last;
                end
            endcase
            for (int c = base + 1; c <= last; c++) begin
                e_stb[c]  = 4'(1 << ix);
                e_adr[c]  = a;
                e_wdat[c] = d;
                e_we[c]   = we;
                e_sel[c]  = sel;
            end
        end
        for (int c = base + 1; c <= endc; c++) begin
            step();
            s_ack_i = '0;
            s_err_i = '0;
            for (int i = 0; i < N; i++)
                s_dat_i[i*32 +: 32] = 32'h5A5A0000 | 32'(i);
            if (h) begin
                if (mode == M_NONE ||
                    ((mode == M_ACK || mode == M_ERR) && c < base + 1 + w)) begin
                    s_ack_i = 4'hF & ~(4'(1) << ix);
                    s_err_i = 4'hF & ~(4'(1) << ix);
                end
                if (mode == M_ACK && c == base + 1 + w) begin
                    s_ack_i[ix]         = 1'b1;
                    s_dat_i[ix*32 +: 32] = rd;
                end
                if (mode == M_ERR && c == base + 1 + w) begin
                    s_ack_i[ix] = 1'b1;
                    s_err_i[ix] = 1'b1;
                end
                if (mode == M_ABORT && c == base + w) begin
                    m_cyc_i = 1'b0;
                    m_stb_i = 1'b0;
                end
            end
        end
    endtask

    initial begin : main
        int b, e;
        for (int k = 0; k < MAXC; k++) begin
            e_stb[k] = '0; e_ack[k] = 1'b0; e_err[k] = 1'b0;
            e_dat[k] = '0; e_adr[k] = '0; e_wdat[k] = '0;
            e_we[k] = 1'b0; e_sel[k] = '0; e_cnt[k] = '0; e_eadr[k] = '0;
        end
        repeat (2) step();
        reset = 1'b0;
        idle(1);

        xfer(32'h104, 32'h0, 1'b0, 4'hF, M_ACK, 0, 32'h0000A5A5, 4'h0, b, e);
        chk("rd104_lat", 32'(e - b), 32'd2);
        chk("rd104_stb_model", 32'(e_stb[b + 1]), 32'h2);
        chk("rd104_ack", 32'(m_ack_o), 32'd1);
        chk("rd104_dat", m_dat_o, 32'h0000A5A5);
        idle(1);

        xfer(32'h300, 32'h80, 1'b1, 4'hF, M_ACK, 3, 32'hFFFFFFFF, 4'h0, b, e);
        chk("wr300_lat", 32'(e - b), 32'd5);
        chk("wr300_ack", 32'(m_ack_o), 32'd1);
        chk("wr300_dat", m_dat_o, 32'h0);
        chk("wr300_sdat", s_dat_o, 32'h80);
        chk("wr300_we", 32'(s_we_o), 32'd1);
        idle(1);

        xfer(32'h500, 32'h0, 1'b0, 4'hF, M_ACK, 0, 32'h0, 4'h0, b, e);
        chk("miss_lat", 32'(e - b), 32'd1);
        chk("miss_err", 32'(m_err_o), 32'd1);
        chk("miss_dat", m_dat_o, 32'hDEADBEEF);
        chk("miss_eadr", err_adr_o, 32'h500);
        chk("miss_ecnt", 32'(err_cnt_o), 32'd1);
        idle(1);

        xfer(32'h200, 32'h0, 1'b0, 4'hF, M_NONE, 0, 32'h0, 4'h0, b, e);
        chk("to_lat", 32'(e - b), 32'd17);
        chk("to_err", 32'(m_err_o), 32'd1);
        chk("to_ecnt", 32'(err_cnt_o), 32'd2);
        idle(2);
        xfer(32'h004, 32'h0, 1'b0, 4'h3, M_ACK, 1, 32'h12345678, 4'h0, b, e);
        chk("rd004_dat", m_dat_o, 32'h12345678);

        xfer(32'h10C, 32'h0, 1'b0, 4'hF, M_ERR, 0, 32'h0, 4'h0, b, e);
        chk("serr_err", 32'(m_err_o), 32'd1);
        chk("serr_ecnt", 32'(err_cnt_o), 32'd3);
        xfer(32'h308, 32'h0, 1'b0, 4'hF, M_ACK, 0, 32'h0BADF00D, 4'h0, b, e);
        chk("b2b_dat", m_dat_o, 32'h0BADF00D);
        idle(1);

        xfer(32'h104, 32'h0, 1'b0, 4'hF, M_ABORT, 2, 32'h0, 4'h0, b, e);
        xfer(32'h000, 32'h0, 1'b0, 4'hF, M_ACK, 0, 32'h600D0000, 4'h2, b, e);
        chk("abort_next_dat", m_dat_o, 32'h600D0000);
        idle(1);

        step();
        b       = cyc;
        m_adr_i = 32'h104;
        m_dat_i = 32'h0;
        m_we_i  = 1'b0;
        m_sel_i = 4'hF;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        for (int c = b + 1; c <= b + 2; c++) begin
            e_stb[c] = 4'h2; e_adr[c] = 32'h104; e_wdat[c] = 32'h0;
            e_we[c] = 1'b0; e_sel[c] = 4'hF;
        end
        step();
        step();
        reset = 1'b1;
        model_reset(b + 3);
        #1;
        chk("rst_stb", 32'(s_stb_o), 32'd0);
        chk("rst_ack", 32'(m_ack_o), 32'd0);
        chk("rst_err", 32'(m_err_o), 32'd0);
        chk("rst_ecnt", 32'(err_cnt_o), 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        step();
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 256; i++)
            xfer(32'h400 + 32'(i * 4), 32'h0, 1'b0, 4'hF, M_ACK, 0,
                 32'h0, 4'h0, b, e);
        chk("sat_ecnt", 32'(err_cnt_o), 32'd255);
        chk("sat_eadr", err_adr_o, 32'h7FC);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule

// File: doc/wb_intercon.md
Name: wb_intercon

Overview:
- Parametrised single-master, N-slave Wishbone classic interconnect. Replaces the hand-written per-peripheral STB gating and ACK/data muxing in the SoC top.
- Sits between the CPU-side bus bridge (master) and peripherals such as GPIO and PWM (slaves).
- Adds four things the old gating lacked: mask/base address decoding, registered responses, a bus-error timeout watchdog, and error-address capture.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- SLAVE_BASE, {32'h300,32'h200,32'h100,32'h000}, packed NUM_SLAVES*ADDR_W; slave i base at slice i.
- SLAVE_MASK, {4{32'hFFFFFF00}}, packed NUM_SLAVES*ADDR_W; slave i decode mask.
- TIMEOUT, 16, cycles in ACTIVE without ACK/ERR before bus error (>=2).
- ERR_DATA, 32'hDEADBEEF, read data returned on error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_adr_i  in  ADDR_W  master address
- m_dat_i  in  DATA_W  master write data
- m_sel_i  in  SEL_W  byte selects
- m_we_i  in  1  write enable
- m_stb_i  in  1  strobe
- m_cyc_i  in  1  cycle
- m_dat_o  out  DATA_W  registered read data
- m_ack_o  out  1  registered acknowledge, 1-cycle pulse
- m_err_o  out  1  registered bus error, 1-cycle pulse
- s_adr_o  out  ADDR_W  latched address to all slaves
- s_dat_o  out  DATA_W  latched write data to all slaves
- s_sel_o  out  SEL_W  latched selects
- s_we_o  out  1  latched write enable
- s_stb_o  out  NUM_SLAVES  one-hot strobe
- s_cyc_o  out  NUM_SLAVES  one-hot cycle
- s_dat_i  in  NUM_SLAVES*DATA_W  slave read data, slave i at slice i
- s_ack_i  in  NUM_SLAVES  slave acknowledges
- s_err_i  in  NUM_SLAVES  slave errors
- err_adr_o  out  ADDR_W  address of the most recent errored transfer
- err_cnt_o  out  8  saturating error count

Behaviour:
- Clock and reset: single clock domain. Asynchronous active-high reset sends all state and outputs to 0, FSM to IDLE, timeout counter to 0.
- Decode: slave i hits when (m_adr_i & MASK[i]) == BASE[i]. On overlapping hits, the lowest index wins. No hit is a miss.
- States: IDLE, ACTIVE, RESP.
- IDLE:
  - On m_cyc_i & m_stb_i at edge T, latch adr/dat/sel/we and the slave index.
  - On a hit, go to ACTIVE; s_stb_o[idx] and s_cyc_o[idx] are high from T+1.
  - On a miss, go to RESP with err flagged, so m_err_o=1 at T+1. No slave strobe is asserted.
- ACTIVE:
  - Strobe is held; the counter increments each cycle.
  - On s_ack_i[idx], register m_dat_o <= s_dat_i[idx] (for writes, m_dat_o <= 0), set m_ack_o next cycle, drop strobe next cycle, go to RESP.
  - s_err_i[idx] is handled like ACK, but returns m_err_o and ERR_DATA.
  - If ACK and ERR arrive together, ERR wins.
  - ACK/ERR from non-selected slaves is ignored.
  - When the counter reaches TIMEOUT-1 with no response, drop strobe, go to RESP, and pulse m_err_o with ERR_DATA.
- Latency: a zero-wait slave (ACK in the first strobe cycle T+1) gives m_ack_o at T+2. Each slave wait state adds 1 cycle.
- RESP: m_ack_o or m_err_o is high for exactly one cycle, then return to IDLE. If the master still holds stb in the cycle after the pulse, that is a new transfer (back-to-back permitted).
- Abort: m_cyc_i low in ACTIVE drops strobe/cyc the next cycle and returns to IDLE. No ACK/ERR, counter cleared.
- Error logging: on every error (miss, slave ERR, timeout), err_adr_o <= latched address and err_cnt_o increments, saturating at 255.
- Invariants: m_ack_o and m_err_o are never high together. At most one s_stb_o bit is high.

Decomposition:
- Package wb_pkg: state enum (IDLE/ACTIVE/RESP), localparam ERR_DATA default, clog2-based index width helper.
- Sub-module wb_addr_decoder: combinational priority decode returning hit flag plus index. Reused by a future multi-master arbiter.

Test Plan:
- Reset mid-ACTIVE (assert reset at T+2 of a read) -> all strobes, ack, err, err_cnt_o = 0 immediately; FSM in IDLE.
- Read 0x104 with slave 1 zero-wait returning 0x0000A5A5 -> s_stb_o=4'b0010 at T+1, m_ack_o=1 with m_dat_o=0x0000A5A5 at T+2, one cycle only.
- Write 0x300 with data 0x80, sel 4'hF, slave 3 delaying ACK by 3 cycles -> s_dat_o=0x80, s_we_o=1; m_ack_o at T+5; no other slave strobed.
- Read unmapped 0x500 -> no s_stb_o bit set, m_err_o=1 at T+1, m_dat_o=0xDEADBEEF, err_adr_o=0x500, err_cnt_o=1.
- Read 0x200, slave 2 never ACKs, TIMEOUT=16 -> strobe held 16 cycles, m_err_o at T+17, err_cnt_o increments; a later read to slave 0 completes normally.
- Abort: drop m_cyc_i at T+2 of a read to slave 1, slave ACKs at T+3 -> no m_ack_o, s_stb_o=0 from T+3; back-to-back transfer accepted at T+3.
